// File: rtl/sdram_rd_stream_ctrl.sv
// Read-FIFO consumer: requests SDRAM read bursts and drains the FIFO into a framed valid/ready stream.
// Optional: define SDRAM_RD_UNDERRUN_CNT_EN to build the stream underrun counter.
module sdram_rd_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 256,
    parameter int LINE_WORDS = 640,
    parameter int LINE_NUM   = 480,
    parameter int ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int SETTLE_CYC = 4
) (
    input  logic                  clkr,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ack,
    input  logic                  rd_done,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic [9:0]            fifo_rdusedw,
    output logic                  fifo_re,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic [15:0]           underrun_cnt
);

    // state     | meaning
    // ST_IDLE   | no burst outstanding; request when frame needs data and FIFO has room
    // ST_REQ    | rd_req held with stable rd_addr until rd_ack
    // ST_WAIT   | burst accepted, waiting for last word written (rd_done)
    // ST_SETTLE | down-count while rdusedw catches up across the synchroniser
    // Output stage: m_valid=0 empty / m_valid=1 holding a word; eof_loaded blocks loads until next frame.
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_SETTLE} req_state_t;

    localparam int FRAME_WORDS = LINE_WORDS * LINE_NUM;
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int X_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int Y_W   = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
    localparam int S_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0]      FRAME_C = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]      BURST_C = CNT_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BURST_A = ADDR_WIDTH'(BURST_LEN);
    localparam logic [9:0]            LVL_MAX = 10'(FIFO_DEPTH - BURST_LEN);
    localparam logic [X_W-1:0]        X_LAST  = X_W'(LINE_WORDS - 1);
    localparam logic [Y_W-1:0]        Y_LAST  = Y_W'(LINE_NUM - 1);
    localparam logic [S_W-1:0]        S_LOAD  = S_W'(SETTLE_CYC - 1);

    req_state_t       state;
    logic [CNT_W-1:0] req_cnt;
    logic [S_W-1:0]   settle_cnt;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             eof_loaded;
    logic             load;
    logic             x_last;
    logic             y_last;

    assign x_last  = (x == X_LAST);
    assign y_last  = (y == Y_LAST);
    assign load    = busy & ~fifo_empty & (~m_valid | m_ready) & ~eof_loaded;
    assign fifo_re = load;

    always_ff @(posedge clkr) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_req     <= 1'b0;
            rd_addr    <= BASE_ADDR;
            req_cnt    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            eof_loaded <= 1'b0;
            x          <= '0;
            y          <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (busy && (req_cnt < FRAME_C) && (fifo_rdusedw <= LVL_MAX)) begin
                        state  <= ST_REQ;
                        rd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        rd_req  <= 1'b0;
                        req_cnt <= req_cnt + BURST_C;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_done) begin
                        rd_addr    <= rd_addr + BURST_A;
                        settle_cnt <= S_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_IDLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_req <= 1'b0;
                end
            endcase

            if (load) begin
                m_data  <= fifo_dout;
                m_valid <= 1'b1;
                m_sof   <= (x == '0) && (y == '0);
                m_eol   <= x_last;
                m_eof   <= x_last && y_last;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                if (x_last && y_last) eof_loaded <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (m_valid && m_ready && m_eof) busy <= 1'b0;

            // A start while busy is dropped so an in-flight frame is never re-aligned.
            if (frame_start && !busy) begin
                busy       <= 1'b1;
                rd_addr    <= BASE_ADDR;
                req_cnt    <= '0;
                x          <= '0;
                y          <= '0;
                eof_loaded <= 1'b0;
            end
        end
    end

`ifdef SDRAM_RD_UNDERRUN_CNT_EN
    always_ff @(posedge clkr) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (frame_start && !busy) begin
            underrun_cnt <= '0;
        end else if (busy && m_ready && !m_valid && fifo_empty &&
                     ((x != '0) || (y != '0)) && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sdram_rd_stream_ctrl.sv
// Bench for sdram_rd_stream_ctrl: queue FIFO model, directed SDRAM responses, word-index stream reference.
// Honours SDRAM_RD_UNDERRUN_CNT_EN when deciding the expected underrun count.
module tb_sdram_rd_stream_ctrl;
    localparam int LW = 8;
    localparam int LN = 4;
    localparam int BL = 16;
    localparam int SC = 4;
    localparam int FW = LW * LN;
`ifdef SDRAM_RD_UNDERRUN_CNT_EN
    localparam int EXP_UNDERRUN = 5;
`else
    localparam int EXP_UNDERRUN = 0;
`endif

    logic        clkr = 1'b0;
    logic        rst, frame_start, busy, rd_req, rd_ack, rd_done;
    logic [23:0] rd_addr;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic [9:0]  fifo_rdusedw, lvl_real = '0, lvl_force_val;
    logic        lvl_force_en, fifo_re;
    logic [15:0] m_data, underrun_cnt;
    logic        m_valid, m_ready, m_sof, m_eol, m_eof;

    logic        push_en, flush;
    logic [15:0] push_data, frame_base;
    int          word_k, rmode, hs_total;
    int          compared = 0, mismatched = 0;

    always #5 clkr = ~clkr;

    sdram_rd_stream_ctrl #(
        .DATA_WIDTH(16), .FIFO_DEPTH(512), .BURST_LEN(BL), .LINE_WORDS(LW),
        .LINE_NUM(LN), .ADDR_WIDTH(24), .BASE_ADDR(24'h0), .SETTLE_CYC(SC)
    ) dut (
        .clkr(clkr), .rst(rst), .frame_start(frame_start), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rdusedw(fifo_rdusedw),
        .fifo_re(fifo_re), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .underrun_cnt(underrun_cnt)
    );

    // Show-ahead FIFO: head word visible, pop on fifo_re, push from the SDRAM side.
    logic [15:0] fq[$];
    logic [15:0] popped;
    always @(posedge clkr) begin
        if (flush) begin
            fq.delete();
        end else begin
            if (fifo_re && fq.size() != 0) popped = fq.pop_front();
            if (push_en) fq.push_back(push_data);
        end
        fifo_dout  <= (fq.size() != 0) ? fq[0] : 16'h0;
        fifo_empty <= (fq.size() == 0);
        lvl_real   <= 10'(fq.size());
    end
    assign fifo_rdusedw = lvl_force_en ? lvl_force_val : lvl_real;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkr);
        #1;
    endtask

    // Stream reference: the n-th word of a frame carries frame_base+n and markers derived from n.
    task automatic monitor();
        int          hs_idx = 0;
        bit          p_stall = 0, p_re = 0, p_eofhs = 0;
        logic [15:0] p_data = '0;
        logic [2:0]  p_mk = '0;
        logic [15:0] e_data;
        forever begin
            @(negedge clkr);
            if (rst) begin
                hs_idx = 0; p_stall = 0; p_re = 0; p_eofhs = 0;
            end else begin
                if (p_stall)
                    check("stall_hold", {m_valid, m_sof, m_eol, m_eof, m_data}, {1'b1, p_mk, p_data});
                if (p_re) check("load_latency", m_valid, 1);
                if (p_eofhs) check("busy_drop", busy, 0);
                p_eofhs = 0;
                if (m_valid && m_ready) begin
                    e_data = 16'(frame_base + hs_idx);
                    check("data", m_data, e_data);
                    check("markers", {m_sof, m_eol, m_eof},
                          {hs_idx == 0, (hs_idx % LW) == LW - 1, hs_idx == FW - 1});
                    p_eofhs = (hs_idx == FW - 1);
                    hs_idx = (hs_idx == FW - 1) ? 0 : hs_idx + 1;
                    hs_total++;
                end
                p_stall = m_valid && !m_ready;
                p_data  = m_data;
                p_mk    = {m_sof, m_eol, m_eof};
                p_re    = fifo_re;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            step();
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    endtask

    task automatic push_word(input bit gapped);
        if (gapped && $urandom_range(0, 3) == 0) step();
        push_en   = 1'b1;
        push_data = 16'(frame_base + word_k);
        word_k++;
        step();
        push_en = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic new_frame(input int mode, input bit rand_base);
        rmode      = mode;
        frame_base = rand_base ? 16'($urandom) : 16'h0;
        word_k     = 0;
    endtask

    // Answers one burst request; hold leaves the controller parked waiting for rd_done.
    task automatic serve_burst(input logic [23:0] a_exp, input int nw, input bit hold);
        int t = 0;
        while (!rd_req && t < 200) begin step(); t++; end
        check("req_seen", rd_req, 1);
        if (!rd_req) return;
        check("req_addr", rd_addr, a_exp);
        repeat ($urandom_range(0, 2)) begin
            step();
            check("req_hold", {rd_req, rd_addr}, {1'b1, a_exp});
        end
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check("req_drop", rd_req, 0);
        for (int i = 0; i < nw; i++) push_word(1'b1);
        if (hold) return;
        repeat ($urandom_range(0, 2)) step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("addr_advance", rd_addr, 24'(a_exp + BL));
        for (int i = 0; i < SC; i++) begin
            check("settle_quiet", rd_req, 0);
            step();
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin step(); t++; end
        check("frame_done", busy, 0);
    endtask

    initial begin
        int          h0, t;
        logic [23:0] a_before;
        rst = 1'b1; frame_start = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
        push_en = 1'b0; push_data = '0; flush = 1'b0; lvl_force_en = 1'b0; lvl_force_val = '0;
        rmode = 0; m_ready = 1'b1; frame_base = '0; word_k = 0; hs_total = 0;
        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) step();
        check("rst_ctrl", {busy, rd_req, fifo_re, m_valid, m_sof, m_eol, m_eof}, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", m_data, 0);
        check("rst_underrun", underrun_cnt, 0);
        rst = 1'b0;
        step();

        // Preloaded frame, ready always high, bursts answered without data.
        new_frame(0, 1'b0);
        for (int i = 0; i < FW; i++) push_word(1'b0);
        step();
        check("no_load_idle", {fifo_re, m_valid}, 0);
        h0 = hs_total;
        pulse_start();
        check("busy_set", busy, 1);
        serve_burst(24'd0, 0, 1'b0);
        serve_burst(24'd16, 0, 1'b0);
        wait_idle(500);
        check("frame1_words", hs_total - h0, FW);
        for (int i = 0; i < 12; i++) begin
            check("no_third_req", rd_req, 0);
            step();
        end

        // Ready toggling each cycle, data arriving per burst.
        new_frame(1, 1'b1);
        h0 = hs_total;
        pulse_start();
        serve_burst(24'd0, BL, 1'b0);
        serve_burst(24'd16, BL, 1'b0);
        wait_idle(1000);
        check("frame2_words", hs_total - h0, FW);

        // FIFO level threshold, then an ignored start mid-frame, random ready.
        new_frame(2, 1'b1);
        lvl_force_en = 1'b1; lvl_force_val = 10'd497;
        h0 = hs_total;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check("no_req_full", rd_req, 0);
            step();
        end
        lvl_force_val = 10'd496;
        step();
        check("req_at_496", rd_req, 1);
        lvl_force_en = 1'b0;
        serve_burst(24'd0, BL, 1'b0);
        a_before = rd_addr;
        pulse_start();
        check("ignore_start_addr", rd_addr, a_before);
        check("ignore_start_busy", busy, 1);
        serve_burst(24'd16, BL, 1'b0);
        wait_idle(1000);
        check("frame3_words", hs_total - h0, FW);

        // Underrun window: 12 words, 5 empty cycles, then the rest; requests left unanswered.
        new_frame(0, 1'b1);
        for (int i = 0; i < 12; i++) push_word(1'b0);
        h0 = hs_total;
        pulse_start();
        t = 0;
        while (!(fifo_empty && !m_valid && (hs_total - h0 == 12)) && t < 200) begin
            @(negedge clkr);
            t++;
        end
        check("gap_found", {fifo_empty, m_valid, busy}, {1'b1, 1'b0, 1'b1});
        repeat (4) @(posedge clkr);
        #1;
        for (int i = 12; i < FW; i++) push_word(1'b0);
        wait_idle(500);
        check("frame4_words", hs_total - h0, FW);
        check("underrun_cnt", underrun_cnt, EXP_UNDERRUN);

        // Reset while waiting for rd_done; stray handshakes afterwards are ignored.
        new_frame(3, 1'b1);
        pulse_start();
        check("underrun_clear", underrun_cnt, 0);
        serve_burst(24'd0, BL, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_wait_ctrl", {rd_req, busy, m_valid, fifo_re}, 0);
        check("rst_wait_addr", rd_addr, 0);
        rst = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0; rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        step();
        check("stray_ack_done", {rd_req, busy, rd_addr}, 0);

        // Clean frame after the abandoned burst.
        new_frame(2, 1'b1);
        h0 = hs_total;
        pulse_start();
        serve_burst(24'd0, BL, 1'b0);
        serve_burst(24'd16, BL, 1'b0);
        wait_idle(1000);
        check("frame6_words", hs_total - h0, FW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sdram_rd_stream_ctrl.md
Name: sdram_rd_stream_ctrl

Overview:
- Read-side consumer of the SDRAM read FIFO (16-bit, show-ahead, 512 deep, `rdusedw` 10 bits), running in the FIFO read clock domain.
- Requests SDRAM read bursts from the SDRAM controller, one burst outstanding at a time, whenever the FIFO has room for a whole burst.
- Drains the FIFO into a registered valid/ready pixel stream and tags each word with line/frame markers for the downstream video/display path.

Parameters:
- DATA_WIDTH, 16, FIFO/stream data width.
- FIFO_DEPTH, 512, words in the read FIFO.
- BURST_LEN, 256, words per SDRAM read burst; LINE_WORDS*LINE_NUM must be a multiple of BURST_LEN.
- LINE_WORDS, 640, words per line.
- LINE_NUM, 480, lines per frame.
- ADDR_WIDTH, 24, SDRAM word-address width.
- BASE_ADDR, 0, frame start address.
- SETTLE_CYC, 4, wait cycles after burst completion to cover `rdusedw` synchroniser lag.

Ports:
- clkr  in  1  read-domain clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; starts a frame.
- busy  out  1  frame in progress.
- rd_req  out  1  burst request to SDRAM controller.
- rd_addr  out  ADDR_WIDTH  burst start address, stable while rd_req=1.
- rd_ack  in  1  one-cycle pulse; request accepted.
- rd_done  in  1  one-cycle pulse; last burst word written to FIFO.
- fifo_dout  in  DATA_WIDTH  FIFO show-ahead data.
- fifo_empty  in  1  FIFO empty_flag.
- fifo_rdusedw  in  10  FIFO read-side level.
- fifo_re  out  1  FIFO read enable.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_sof  out  1  first word of frame.
- m_eol  out  1  last word of line.
- m_eof  out  1  last word of frame.
- underrun_cnt  out  16  see Optional Feature.

Behaviour:
- Reset: all outputs 0; `rd_addr`=BASE_ADDR; all counters 0; both FSMs in IDLE.
- FIFO contents are not flushed by this block.
- Frame control:
  - `frame_start` with busy=0: set busy, set `rd_addr`=BASE_ADDR, clear `req_cnt`, `x`, `y`.
  - `frame_start` with busy=1 is ignored.
  - busy clears on the cycle after the `m_eof` word handshakes (`m_valid` & `m_ready`).
- Request FSM: IDLE -> REQ -> WAIT -> SETTLE -> IDLE.
  - IDLE -> REQ when busy, `req_cnt` < LINE_WORDS*LINE_NUM, and `fifo_rdusedw` <= FIFO_DEPTH-BURST_LEN.
  - REQ: `rd_req`=1 until `rd_ack`. On `rd_ack`: `req_cnt`+=BURST_LEN; go to WAIT.
  - WAIT -> SETTLE on `rd_done`; `rd_addr`+=BURST_LEN, wrapping mod 2^ADDR_WIDTH.
  - SETTLE counts SETTLE_CYC cycles, then returns to IDLE.
  - `rd_ack` and `rd_done` outside REQ/WAIT are ignored.
- Output stage, single register:
  - load = busy & ~fifo_empty & (~m_valid | m_ready).
  - `fifo_re` = load.
  - On load: `m_data` <= `fifo_dout`; `m_valid` <= 1. Otherwise, when `m_ready` is high, `m_valid` <= 0.
  - Latency: 1 cycle from FIFO word present to `m_valid`. With ready held high, throughput is 1 word/cycle.
  - While m_valid=1 & m_ready=0, `m_data` and the markers hold.
- Markers, registered with the data on load:
  - m_sof = (x==0 & y==0).
  - m_eol = (x==LINE_WORDS-1).
  - m_eof = m_eol & (y==LINE_NUM-1).
  - x advances on load and wraps to 0 at LINE_WORDS-1, incrementing y; y wraps to 0 after LINE_NUM-1.
- No load after the `m_eof` word is loaded until the next frame; stray FIFO data stays in the FIFO.
- Reset mid-burst: FSM returns to IDLE and `rd_req` drops. The controller must tolerate the abandoned request.

Optional Feature:
- Macro: SDRAM_RD_UNDERRUN_CNT_EN.
- Defined: `underrun_cnt` increments (saturating at 16'hFFFF) on each cycle with busy & m_ready & ~m_valid & fifo_empty & (x|y)!=0, i.e. after the frame's first word. It clears on reset and on an accepted `frame_start`.
- Undefined: `underrun_cnt` is tied to 0 and no counter logic is built.

Test Plan (LINE_WORDS=8, LINE_NUM=4, BURST_LEN=16, SETTLE_CYC=4):
- Reset then `frame_start`, `fifo_rdusedw`=0 -> `rd_req`=1, `rd_addr`=0. After `rd_ack` and `rd_done` -> next request has `rd_addr`=16 after 4 settle cycles. Exactly 2 requests per frame.
- FIFO model preloaded with 32 words 0..31, m_ready=1 -> m_valid on the cycle after `fifo_re`. Data 0..31 in order. m_eol on 7, 15, 23, 31; m_sof on 0; m_eof on 31; busy drops the next cycle.
- m_ready toggled 1/0 every cycle -> no data lost or duplicated. `m_data` stable while stalled. 32 handshakes total.
- `fifo_rdusedw`=497 (>496) while idle -> no `rd_req`. Drop to 496 -> `rd_req` next cycle.
- `frame_start` pulsed mid-frame -> ignored; counters and `rd_addr` unchanged. `rst` asserted in WAIT -> `rd_req`=0, busy=0, m_valid=0 the next cycle.
- With SDRAM_RD_UNDERRUN_CNT_EN defined: FIFO empty for 5 cycles mid-frame with m_ready=1 -> `underrun_cnt`=5. Without the macro -> `underrun_cnt`=0.
